// File: rtl/conv_pixel_sequencer.sv
// rtl/conv_pixel_sequencer.sv - per-output-pixel conv sequencer over mac_int8/leaky_relu/requantize
// Optional perf counters (perf_cycles/perf_stall) when SEQ_PERF_CNT_EN is defined.
module conv_pixel_sequencer #(
  parameter int MAX_MACS = 288,
  parameter int MAX_CH   = 32,
  parameter int W_AW     = 14
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [9:0]                  cfg_num_macs,
  input  logic [5:0]                  cfg_num_ch,
  input  logic [15:0]                 cfg_scale,
  output logic [W_AW-1:0]             w_addr,
  input  logic [7:0]                  w_data,
  output logic [$clog2(MAX_MACS)-1:0] a_addr,
  input  logic [7:0]                  a_data,
  output logic [$clog2(MAX_CH)-1:0]   b_addr,
  input  logic [31:0]                 b_data,
  output logic                        mac_valid,
  output logic [7:0]                  mac_weight,
  output logic [7:0]                  mac_act,
  output logic [31:0]                 mac_acc_in,
  input  logic [31:0]                 mac_acc_out,
  input  logic                        mac_done,
  output logic                        lk_valid,
  output logic [31:0]                 lk_x,
  input  logic [31:0]                 lk_y,
  input  logic                        lk_done,
  output logic                        rq_valid,
  output logic [31:0]                 rq_acc,
  output logic [15:0]                 rq_scale,
  input  logic [7:0]                  rq_out,
  input  logic                        rq_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_data,
  output logic [$clog2(MAX_CH)-1:0]   out_ch,
  output logic                        busy,
  output logic                        done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_cycles,
  output logic [31:0]                 perf_stall
`endif
);

  localparam int AAW = $clog2(MAX_MACS);
  localparam int BAW = $clog2(MAX_CH);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_FETCH, S_MAC_ISS, S_MAC_WT, S_BIAS_RD, S_BIAS_ADD,
    S_LK_ISS, S_LK_WT, S_RQ_ISS, S_RQ_WT, S_OUT, S_FIN
  } state_t;

  state_t state, next_state;

  logic [9:0]      num_macs_q;
  logic [5:0]      num_ch_q;
  logic [15:0]     scale_q;
  logic [9:0]      i_q;
  logic [5:0]      ch_q;
  logic [W_AW-1:0] w_base_q;
  logic [31:0]     acc_q;
  logic [31:0]     lk_x_q;
  logic [31:0]     rq_acc_q;
  logic [7:0]      out_data_q;

  logic accept;
  logic last_mac;
  logic last_ch;

  assign accept   = (state == S_IDLE) && start;
  assign last_mac = ((i_q + 10'd1) == num_macs_q);
  assign last_ch  = ((ch_q + 6'd1) == num_ch_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start) next_state = S_LOAD;
      S_LOAD: begin
        if (num_ch_q == 6'd0)        next_state = S_FIN;
        else if (num_macs_q == 10'd0) next_state = S_BIAS_RD;
        else                          next_state = S_FETCH;
      end
      S_FETCH:    next_state = S_MAC_ISS;
      S_MAC_ISS:  next_state = S_MAC_WT;
      S_MAC_WT:   if (mac_done) next_state = last_mac ? S_BIAS_RD : S_FETCH;
      S_BIAS_RD:  next_state = S_BIAS_ADD;
      S_BIAS_ADD: next_state = S_LK_ISS;
      S_LK_ISS:   next_state = S_LK_WT;
      S_LK_WT:    if (lk_done) next_state = S_RQ_ISS;
      S_RQ_ISS:   next_state = S_RQ_WT;
      S_RQ_WT:    if (rq_done) next_state = S_OUT;
      S_OUT:      if (out_ready) next_state = last_ch ? S_FIN : S_LOAD;
      S_FIN:      next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Strobes are pure state decodes; MAC operands are gated so the bus idles at zero.
  always_comb begin
    mac_valid  = 1'b0;
    lk_valid   = 1'b0;
    rq_valid   = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    mac_weight = 8'd0;
    mac_act    = 8'd0;
    mac_acc_in = 32'd0;
    case (state)
      S_MAC_ISS: begin
        mac_valid  = 1'b1;
        mac_weight = w_data;
        mac_act    = a_data;
        mac_acc_in = acc_q;
      end
      S_LK_ISS: lk_valid  = 1'b1;
      S_RQ_ISS: rq_valid  = 1'b1;
      S_OUT:    out_valid = 1'b1;
      S_FIN:    done      = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_macs_q <= '0;
      num_ch_q   <= '0;
      scale_q    <= '0;
      i_q        <= '0;
      ch_q       <= '0;
      w_base_q   <= '0;
      acc_q      <= '0;
      lk_x_q     <= '0;
      rq_acc_q   <= '0;
      out_data_q <= '0;
    end else begin
      if (accept) begin
        num_macs_q <= cfg_num_macs;
        num_ch_q   <= cfg_num_ch;
        scale_q    <= cfg_scale;
        ch_q       <= '0;
        w_base_q   <= '0;
      end
      case (state)
        S_LOAD: begin
          acc_q <= '0;
          i_q   <= '0;
        end
        S_MAC_WT: if (mac_done) begin
          acc_q <= mac_acc_out;
          i_q   <= i_q + 10'd1;
        end
        S_BIAS_ADD: lk_x_q <= acc_q + b_data;
        S_LK_WT:    if (lk_done) rq_acc_q <= lk_y;
        S_RQ_WT:    if (rq_done) out_data_q <= rq_out;
        // Weight base advances by one channel stride on each transfer; no multiplier.
        S_OUT: if (out_ready) begin
          ch_q     <= ch_q + 6'd1;
          w_base_q <= w_base_q + {{(W_AW-10){1'b0}}, num_macs_q};
        end
        default: ;
      endcase
    end
  end

  assign w_addr   = w_base_q + {{(W_AW-10){1'b0}}, i_q};
  assign a_addr   = i_q[AAW-1:0];
  assign b_addr   = ch_q[BAW-1:0];
  assign lk_x     = lk_x_q;
  assign rq_acc   = rq_acc_q;
  assign rq_scale = scale_q;
  assign out_data = out_data_q;
  assign out_ch   = ch_q[BAW-1:0];

`ifdef SEQ_PERF_CNT_EN
  // Counts every busy cycle (LOAD through FIN), so it freezes once back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state != S_IDLE) begin
      perf_cycles <= perf_cycles + 32'd1;
      if ((state == S_OUT) && !out_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  // Perf counters compiled out.
`endif

endmodule

// File: tb/tb_conv_pixel_sequencer.sv
// tb/tb_conv_pixel_sequencer.sv - randomized self-checking bench for conv_pixel_sequencer
module tb_conv_pixel_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [9:0]  cfg_num_macs;
  logic [5:0]  cfg_num_ch;
  logic [15:0] cfg_scale;
  logic [13:0] w_addr;
  logic [7:0]  w_data;
  logic [8:0]  a_addr;
  logic [7:0]  a_data;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        mac_valid, mac_done;
  logic [7:0]  mac_weight, mac_act;
  logic [31:0] mac_acc_in, mac_acc_out;
  logic        lk_valid, lk_done;
  logic [31:0] lk_x, lk_y;
  logic        rq_valid, rq_done;
  logic [31:0] rq_acc;
  logic [15:0] rq_scale;
  logic [7:0]  rq_out;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [4:0]  out_ch;
  logic        busy, done;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  conv_pixel_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_num_macs(cfg_num_macs), .cfg_num_ch(cfg_num_ch), .cfg_scale(cfg_scale),
    .w_addr(w_addr), .w_data(w_data), .a_addr(a_addr), .a_data(a_data),
    .b_addr(b_addr), .b_data(b_data),
    .mac_valid(mac_valid), .mac_weight(mac_weight), .mac_act(mac_act),
    .mac_acc_in(mac_acc_in), .mac_acc_out(mac_acc_out), .mac_done(mac_done),
    .lk_valid(lk_valid), .lk_x(lk_x), .lk_y(lk_y), .lk_done(lk_done),
    .rq_valid(rq_valid), .rq_acc(rq_acc), .rq_scale(rq_scale), .rq_out(rq_out), .rq_done(rq_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .busy(busy), .done(done)
`ifdef SEQ_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Models of the external arithmetic units and memories.
  function automatic logic signed [31:0] leaky(input logic signed [31:0] x);
    return (x < 0) ? (x >>> 3) : x;
  endfunction

  function automatic logic [7:0] requant(input logic signed [31:0] x, input logic [15:0] s);
    longint p;
    p = longint'(x) * longint'(s);
    p = p >>> 16;
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    return p[7:0];
  endfunction

  logic [7:0]  wmem [0:16383];
  logic [7:0]  amem [0:511];
  logic [31:0] bmem [0:31];

  always @(posedge clk) begin
    w_data <= wmem[w_addr];
    a_data <= amem[a_addr];
    b_data <= bmem[b_addr];
  end

  int mac_cnt, lk_cnt, rq_cnt, mac_lat, lk_lat, rq_lat, proto_err, done_cnt;
  logic signed [31:0] last_lk_x;

  initial begin
    mac_done = 1'b0; mac_acc_out = '0;
    forever begin
      @(negedge clk);
      if (mac_valid) begin
        logic signed [7:0] wv, av;
        logic signed [31:0] ai;
        int d;
        wv = mac_weight; av = mac_act; ai = mac_acc_in;
        d = $urandom_range(1, 3);
        mac_cnt++; mac_lat += d;
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          if (mac_valid) proto_err++;
        end
        mac_acc_out = ai + wv * av;
        mac_done = 1'b1;
        @(negedge clk);
        mac_done = 1'b0;
      end
    end
  end

  initial begin
    lk_done = 1'b0; lk_y = '0;
    forever begin
      @(negedge clk);
      if (lk_valid) begin
        int d;
        last_lk_x = lk_x;
        d = $urandom_range(1, 3);
        lk_cnt++; lk_lat += d;
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          if (lk_valid) proto_err++;
        end
        lk_y = leaky(last_lk_x);
        lk_done = 1'b1;
        @(negedge clk);
        lk_done = 1'b0;
      end
    end
  end

  initial begin
    rq_done = 1'b0; rq_out = '0;
    forever begin
      @(negedge clk);
      if (rq_valid) begin
        logic signed [31:0] x;
        logic [15:0] s;
        int d;
        x = rq_acc; s = rq_scale;
        d = $urandom_range(1, 3);
        rq_cnt++; rq_lat += d;
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          if (rq_valid) proto_err++;
        end
        rq_out = requant(x, s);
        rq_done = 1'b1;
        @(negedge clk);
        rq_done = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  // Result sink: mode 0 always ready, 1 random, 2 holds ch1 for 20 cycles.
  int ready_mode, stall_n, stall_sum, stab_err;
  int beat_ch[$];
  logic [7:0] beat_data[$];
  logic [7:0] stall_d;
  logic [4:0] stall_c;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (out_valid && out_ch == 5'd1 && stall_n < 20) begin
        out_ready = 1'b0;
        if (stall_n == 0) begin
          stall_d = out_data; stall_c = out_ch;
        end else if (out_data !== stall_d || out_ch !== stall_c || mac_valid) stab_err++;
        stall_n++;
      end else out_ready = 1'b1;
      if (out_valid) begin
        if (out_ready) begin
          beat_ch.push_back(int'(out_ch));
          beat_data.push_back(out_data);
        end else stall_sum++;
      end
    end
  end

  task automatic fill(input int n_macs, input int n_ch);
    for (int k = 0; k < n_macs * n_ch; k++) wmem[k] = 8'($urandom);
    for (int k = 0; k < n_macs; k++) amem[k] = 8'($urandom);
    for (int k = 0; k < 32; k++) bmem[k] = 32'($urandom_range(0, 40000)) - 32'd20000;
  endtask

  task automatic run_pixel(input string tag, input int n_macs, input int n_ch,
                           input logic [15:0] scale, input int mode, input bit repulse);
    int lat, exp_lat;
    bit got;
    beat_ch.delete(); beat_data.delete();
    mac_cnt = 0; lk_cnt = 0; rq_cnt = 0; mac_lat = 0; lk_lat = 0; rq_lat = 0;
    stall_n = 0; stall_sum = 0; stab_err = 0;
    ready_mode = mode;
    @(negedge clk);
    cfg_num_macs = 10'(n_macs); cfg_num_ch = 6'(n_ch); cfg_scale = scale;
    start = 1'b1;
    lat = 0; got = 1'b0;
    while (lat < 30000) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (repulse && lat == 6) begin
        start = 1'b1; cfg_num_ch = 6'd0; cfg_num_macs = 10'd1; cfg_scale = 16'd1;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, 64'(got), 64'd1);
    if (n_ch == 0) exp_lat = 2;
    else exp_lat = 1 + n_ch * (6 + 2 * n_macs) + mac_lat + lk_lat + rq_lat + stall_sum;
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_mac_count"}, 64'(mac_cnt), 64'(n_macs * n_ch));
    check_eq({tag, "_lk_count"}, 64'(lk_cnt), 64'(n_ch));
    check_eq({tag, "_beats"}, 64'(beat_ch.size()), 64'(n_ch));
    for (int c = 0; c < n_ch && c < beat_ch.size(); c++) begin
      logic signed [31:0] s;
      logic signed [7:0] wv, av;
      s = bmem[c];
      for (int i = 0; i < n_macs; i++) begin
        wv = wmem[c * n_macs + i];
        av = amem[i];
        s = s + wv * av;
      end
      check_eq({tag, "_ch"}, 64'(beat_ch[c]), 64'(c));
      check_eq({tag, "_data"}, 64'(beat_data[c]), 64'(requant(leaky(s), scale)));
    end
`ifdef SEQ_PERF_CNT_EN
    check_eq({tag, "_perf_cycles"}, 64'(perf_cycles), 64'(exp_lat));
    check_eq({tag, "_perf_stall"}, 64'(perf_stall), 64'(stall_sum));
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ctl"}, {17'd0, busy, done, mac_valid, lk_valid, rq_valid, out_valid,
                             out_ch, out_data, b_addr, a_addr, w_addr}, 64'd0);
    check_eq({tag, "_data"}, {8'd0, mac_acc_in | lk_x | rq_acc, mac_weight | mac_act, rq_scale}, 64'd0);
  endtask

  initial begin
    int base;
    bit seen;
    rst_n = 1'b0; start = 1'b0;
    cfg_num_macs = '0; cfg_num_ch = '0; cfg_scale = '0;
    ready_mode = 0; done_cnt = 0; proto_err = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    fill(288, 4);
    run_pixel("full", 288, 4, 16'd655, 0, 1'b0);

    for (int k = 0; k < 32; k++) bmem[k] = 32'd0;
    wmem[0] = 8'd2; amem[0] = 8'd3; bmem[0] = 32'hFFFF_FFF6;
    base = done_cnt;
    run_pixel("single", 1, 1, 16'd40000, 0, 1'b0);
    check_eq("single_lk_x", last_lk_x, -32'sd4);
    repeat (3) @(negedge clk);
    check_eq("single_done_once", 64'(done_cnt - base), 64'd1);

    fill(6, 3);
    run_pixel("stall", 6, 3, 16'd3000, 2, 1'b0);
    check_eq("stall_cycles", 64'(stall_n), 64'd20);
    check_eq("stall_stable", 64'(stab_err), 64'd0);

    base = done_cnt;
    run_pixel("no_ch", 4, 0, 16'd100, 0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("no_ch_done_once", 64'(done_cnt - base), 64'd1);
    fill(0, 3);
    run_pixel("no_macs", 0, 3, 16'd5000, 1, 1'b0);

    for (int k = 0; k < 4; k++) begin wmem[k] = 8'd127; amem[k] = 8'd127; end
    bmem[0] = 32'h7FFF_FF00; bmem[1] = 32'h7FFF_FFFF;
    run_pixel("wrap", 2, 2, 16'd1, 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      int nm, nc;
      nm = $urandom_range(1, 20); nc = $urandom_range(1, 6);
      fill(nm, nc);
      run_pixel("rand", nm, nc, 16'($urandom_range(1, 65535)), 1, 1'b0);
    end

    fill(8, 3);
    run_pixel("repulse", 8, 3, 16'd2000, 1, 1'b1);

    fill(5, 2);
    ready_mode = 0;
    @(negedge clk);
    cfg_num_macs = 10'd5; cfg_num_ch = 6'd2; cfg_scale = 16'd777;
    start = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mac_valid) begin seen = 1'b1; break; end
    end
    check_eq("abort_mac_seen", 64'(seen), 64'd1);
    @(negedge clk);
    base = done_cnt;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("abort_no_done", 64'(done_cnt - base), 64'd0);
    check_eq("abort_idle", 64'(busy), 64'd0);
    fill(5, 2);
    run_pixel("after_abort", 5, 2, 16'd777, 0, 1'b0);

    fill(2, 1);
    run_pixel("perf", 2, 1, 16'd1234, 0, 1'b0);

    check_eq("protocol", 64'(proto_err), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
